arrow_sprite_reader: RTL
========================

Name: arrow_sprite_reader

Overview:
Pixel-side consumer of the lane dropper outputs: drop X/Y position, 40x40 arrow bitmap, and score level.
- Each clock, resolves whether the current VGA pixel (DrawX, DrawY) hits a lit arrow bitmap bit in any lane, through a 2-stage pipeline.
- Reports the winning lane to the color mapper.
- Edge-detects the per-lane score levels and accumulates a saturating game score for the score display.

Parameters:
NUM_LANES, 4, number of dropper lanes consumed (1..8)
SPRITE_W, 40, arrow bitmap width in pixels
SPRITE_H, 40, arrow bitmap height in pixels

Ports:
Clk  input  1  pixel clock; all state on rising edge
Reset  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse at start of vertical blank
DrawX  input  10  current pixel column
DrawY  input  10  current pixel row
dropX  input  10*NUM_LANES  lane i X position at bits [10i+9:10i]
dropY  input  10*NUM_LANES  lane i Y position at bits [10i+9:10i]
arrow  input  SPRITE_W*SPRITE_H*NUM_LANES  lane i bitmap at bits [1600i+1599:1600i]; bit index = row*SPRITE_W + col
score  input  NUM_LANES  lane score level (held high while hit registered)
pixel_on  output  1  current pipelined pixel is a lit arrow bit
pixel_lane  output  3  lane index of winning arrow; 0 when pixel_on=0
score_total  output  16  saturating hit count
hit_pulse  output  1  one-cycle pulse on any cycle where score_total is incremented

Behaviour:
- Reset (synchronous, active-high): pixel_on=0, pixel_lane=0, score_total=0, hit_pulse=0, all pipeline valid bits=0, score edge registers=0, shadow positions=0. Reset mid-frame discards in-flight pipeline contents.
- Position shadow (see Optional Feature): shadowX/shadowY per lane.
- Stage 1, registered:
  - Per lane: in_box = DrawX >= X && DrawX < X+SPRITE_W && DrawY >= Y && DrawY < Y+SPRITE_H. Compare with 11-bit sums so X+40 never wraps; X=1000 gives a box ending at 1040, not wrapped.
  - Register in_box and the bit offset (DrawY-Y)*SPRITE_W + (DrawX-X), 11 bits, only meaningful when in_box.
- Stage 2, registered:
  - Per lane: lit = in_box_r && arrow[lane][offset_r]. The bitmap is sampled live at stage 2, not latched, so a dropper that has finished (all-zero bitmap) disappears immediately.
  - Priority: lowest lane index with lit=1 wins. pixel_on = OR of lit. pixel_lane = winning index, else 0.
- Latency: pixel_on/pixel_lane correspond to DrawX/DrawY presented exactly 2 clocks earlier. The color mapper delays DrawX/DrawY to match.
- Score path:
  - score_prev <= score each clock.
  - rise = score & ~score_prev.
  - Increment = popcount(rise), 0..NUM_LANES.
  - score_total <= min(score_total + increment, 16'hFFFF).
  - hit_pulse <= (increment != 0) && score_total != 16'hFFFF.
  - A level held high counts once. Simultaneous rises in multiple lanes all count in the same cycle.
- A score level that is already high when Reset deasserts does not count: score_prev is reset to 0, but rise is masked on the first cycle after Reset.

Optional Feature:
Macro: ARROW_FRAME_LATCH_EN
- Defined: shadowX/shadowY load from dropX/dropY only on cycles with frame_start=1. Stage 1 uses the shadows, so positions are tear-free within a frame. Shadows are 0 until the first frame_start after Reset.
- Undefined: no shadow registers; stage 1 uses dropX/dropY directly and frame_start is ignored.

Test Plan:
1. Lane0 X=500,Y=100, arrow bit 420 set, drive DrawX=520, DrawY=110 at cycle t -> pixel_on=1, pixel_lane=0 at t+2; DrawX=500, DrawY=100 (bit 0 clear) -> pixel_on=0.
2. Lanes 1 and 2 both at (200,200), both bitmaps with bit 0 set, pixel (200,200) -> pixel_on=1, pixel_lane=1; DrawX=240 (outside box) -> pixel_on=0.
3. Lane 3 score held high for 5 cycles from score_total=7 -> score_total=8, hit_pulse high exactly one cycle.
4. Lanes 0 and 2 score rise on the same cycle from score_total=0 -> score_total=2 in one step; preload 16'hFFFE plus the same stimulus -> 16'hFFFF, with a further rise holding at FFFF and hit_pulse=0.
5. Reset asserted while pixel_on=1 and score_total=20 -> next cycle pixel_on=0, score_total=0; score held high through the reset release -> no increment.
6. With ARROW_FRAME_LATCH_EN defined: change dropY from 100 to 150 mid-frame -> hit still resolved at Y=100 until the frame_start pulse, then at Y=150.

Source files
------------

// File: rtl/arrow_sprite_reader.sv
// rtl/arrow_sprite_reader.sv - pixel hit resolver for dropper arrow sprites plus saturating score counter
// Optional build macro ARROW_FRAME_LATCH_EN latches lane positions at frame_start for tear-free drawing.
module arrow_sprite_reader #(
    parameter int NUM_LANES = 4,
    parameter int SPRITE_W  = 40,
    parameter int SPRITE_H  = 40
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                frame_start,
    input  logic [9:0]                          DrawX,
    input  logic [9:0]                          DrawY,
    input  logic [10*NUM_LANES-1:0]             dropX,
    input  logic [10*NUM_LANES-1:0]             dropY,
    input  logic [SPRITE_W*SPRITE_H*NUM_LANES-1:0] arrow,
    input  logic [NUM_LANES-1:0]                score,
    output logic                                pixel_on,
    output logic [2:0]                          pixel_lane,
    output logic [15:0]                         score_total,
    output logic                                hit_pulse
);

    localparam int          LP_AREA = SPRITE_W * SPRITE_H;
    localparam logic [10:0] LP_W11  = 11'(SPRITE_W);
    localparam logic [10:0] LP_H11  = 11'(SPRITE_H);

    logic [10*NUM_LANES-1:0] w_pos_x;
    logic [10*NUM_LANES-1:0] w_pos_y;

`ifdef ARROW_FRAME_LATCH_EN
    logic [10*NUM_LANES-1:0] r_shadow_x;
    logic [10*NUM_LANES-1:0] r_shadow_y;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shadow_x <= '0;
            r_shadow_y <= '0;
        end else if (frame_start) begin
            r_shadow_x <= dropX;
            r_shadow_y <= dropY;
        end
    end

    assign w_pos_x = r_shadow_x;
    assign w_pos_y = r_shadow_y;
`else
    logic w_unused_frame_start;
    assign w_unused_frame_start = frame_start;
    assign w_pos_x = dropX;
    assign w_pos_y = dropY;
`endif

    logic [NUM_LANES-1:0] w_in_box;
    logic [10:0]          w_off [NUM_LANES];
    logic [NUM_LANES-1:0] r_in_box;
    logic [10:0]          r_off [NUM_LANES];
    logic [NUM_LANES-1:0] w_lit;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [10:0]        w_x, w_y, w_dx, w_dy;
        logic [LP_AREA-1:0] w_bmp;

        // 11-bit compares so a sprite near the right/bottom edge never wraps its box end
        assign w_x  = {1'b0, w_pos_x[10*g +: 10]};
        assign w_y  = {1'b0, w_pos_y[10*g +: 10]};
        assign w_dx = {1'b0, DrawX};
        assign w_dy = {1'b0, DrawY};
        assign w_in_box[g] = (w_dx >= w_x) && (w_dx < w_x + LP_W11) &&
                             (w_dy >= w_y) && (w_dy < w_y + LP_H11);
        assign w_off[g]    = (w_dy - w_y) * LP_W11 + (w_dx - w_x);

        // bitmap read live so a cleared dropper vanishes without a frame of lag
        assign w_bmp    = arrow[g*LP_AREA +: LP_AREA];
        assign w_lit[g] = r_in_box[g] & w_bmp[r_off[g]];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_in_box <= '0;
            for (int l = 0; l < NUM_LANES; l++) r_off[l] <= '0;
        end else begin
            r_in_box <= w_in_box;
            for (int l = 0; l < NUM_LANES; l++) r_off[l] <= w_off[l];
        end
    end

    logic [2:0] w_lane;

    always_comb begin
        w_lane = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (w_lit[l]) w_lane = 3'(l);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_on   <= 1'b0;
            pixel_lane <= '0;
        end else begin
            pixel_on   <= |w_lit;
            pixel_lane <= w_lane;
        end
    end

    logic [NUM_LANES-1:0] r_score_prev;
    logic                 r_mask_rise;
    logic [NUM_LANES-1:0] w_rise;
    logic [3:0]           w_inc;
    logic [16:0]          w_sum;
    logic [15:0]          w_next_total;

    // the first cycle after Reset ignores levels that were already high
    assign w_rise = r_mask_rise ? '0 : (score & ~r_score_prev);

    always_comb begin
        w_inc = '0;
        for (int l = 0; l < NUM_LANES; l++) w_inc = w_inc + 4'(w_rise[l]);
    end

    assign w_sum        = {1'b0, score_total} + 17'(w_inc);
    assign w_next_total = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_score_prev <= '0;
            r_mask_rise  <= 1'b1;
            score_total  <= '0;
            hit_pulse    <= 1'b0;
        end else begin
            r_score_prev <= score;
            r_mask_rise  <= 1'b0;
            score_total  <= w_next_total;
            hit_pulse    <= (w_inc != 4'd0) && (score_total != 16'hFFFF);
        end
    end

endmodule
